// File: rtl/alu_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_sequencer_if : register-file and ALU bus between sequencer and datapath  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface alu_sequencer_if #(
  parameter int RF_AW = 3
) ();
  logic [RF_AW-1:0] rf_raddr_a;
  logic [RF_AW-1:0] rf_raddr_b;
  logic [15:0]      rf_rdata_a;
  logic [15:0]      rf_rdata_b;
  logic             rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [15:0]      rf_wdata;
  logic [15:0]      alu_op1;
  logic [15:0]      alu_op2;
  logic [5:0]       alu_instr;
  logic [15:0]      alu_psw;
  logic             alu_opt;
  logic             alu_e;
  logic [15:0]      alu_result;
  logic [15:0]      alu_psw_o;

  modport master (
    output rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    output alu_op1, alu_op2, alu_instr, alu_psw, alu_opt, alu_e,
    input  rf_rdata_a, rf_rdata_b, alu_result, alu_psw_o
  );

  modport slave (
    input  rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    input  alu_op1, alu_op2, alu_instr, alu_psw, alu_opt, alu_e,
    output rf_rdata_a, rf_rdata_b, alu_result, alu_psw_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_sequencer : runs one ALU instruction read -> strobe -> capture -> write  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module alu_sequencer #(
  parameter int          RF_AW   = 3,
  parameter logic [15:0] PSW_RST = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       instr_i,
  input  logic [RF_AW-1:0] src_i,
  input  logic [RF_AW-1:0] dst_i,
  input  logic             psw_upd_i,
  input  logic             psw_wr,
  input  logic [15:0]      psw_wdata,
  output logic [15:0]      psw,
  output logic             busy,
  output logic             done,
  output logic             err,
  alu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_STROBE = 3'd2,
    S_CAPT   = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [5:0] C_LAST_OP = 6'h1B;

  state_t           state_q, state_d;
  logic [5:0]       instr_q, instr_d;
  logic [RF_AW-1:0] src_q, src_d;
  logic [RF_AW-1:0] dst_q, dst_d;
  logic             upd_q, upd_d;
  logic [15:0]      op1_q, op1_d;
  logic [15:0]      op2_q, op2_d;
  logic [15:0]      res_q, res_d;
  logic [15:0]      pswc_q, pswc_d;
  logic [15:0]      psw_q, psw_d;
  logic             rf_we_w;
  logic             alu_e_w;
  logic             no_wb_w;

  // Compare and bit-test only produce flags; the destination is left untouched.
  assign no_wb_w = (instr_q == 6'h0A) || (instr_q == 6'h0B) ||
                   (instr_q == 6'h12) || (instr_q == 6'h13);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      upd_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      pswc_q  <= '0;
      psw_q   <= PSW_RST;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      upd_q   <= upd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      pswc_q  <= pswc_d;
      psw_q   <= psw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    src_d   = src_q;
    dst_d   = dst_q;
    upd_d   = upd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    pswc_d  = pswc_q;
    psw_d   = psw_q;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    err     = 1'b0;
    rf_we_w = 1'b0;
    alu_e_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The PSW load lands before READ, so a same-cycle start sees psw_wdata.
        if (psw_wr) psw_d = psw_wdata;
        if (start) begin
          if (instr_i <= C_LAST_OP) begin
            instr_d = instr_i;
            src_d   = src_i;
            dst_d   = dst_i;
            upd_d   = psw_upd_i;
            state_d = S_READ;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_READ: begin
        op1_d   = bus.rf_rdata_a;
        op2_d   = bus.rf_rdata_b;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        alu_e_w = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        res_d   = bus.alu_result;
        pswc_d  = bus.alu_psw_o;
        state_d = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        rf_we_w = !no_wb_w;
        psw_d   = pswc_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign psw            = psw_q;
  assign bus.rf_raddr_a = dst_q;
  assign bus.rf_raddr_b = src_q;
  assign bus.rf_we      = rf_we_w;
  assign bus.rf_waddr   = dst_q;
  assign bus.rf_wdata   = res_q;
  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign bus.alu_instr  = instr_q;
  assign bus.alu_psw    = psw_q;
  assign bus.alu_opt    = upd_q;
  assign bus.alu_e      = alu_e_w;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_alu_sequencer : scoreboard bench with RF/ALU environment and ref model   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_alu_sequencer;
  localparam int          AW   = 3;
  localparam logic [15:0] PRST = 16'h0010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    instr_i = '0;
  logic [AW-1:0] src_i = '0;
  logic [AW-1:0] dst_i = '0;
  logic          psw_upd_i = 1'b0;
  logic          psw_wr = 1'b0;
  logic [15:0]   psw_wdata = '0;
  logic [15:0]   psw;
  logic          busy, done, err;

  alu_sequencer_if #(.RF_AW(AW)) bus ();

  alu_sequencer #(.RF_AW(AW), .PSW_RST(PRST)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .instr_i   (instr_i),
    .src_i     (src_i),
    .dst_i     (dst_i),
    .psw_upd_i (psw_upd_i),
    .psw_wr    (psw_wr),
    .psw_wdata (psw_wdata),
    .psw       (psw),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // ALU behaviour: add, addc, cmp (sub), bit (and); anything else xors in the opcode.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] p,
                                         input logic opt);
    logic [16:0] s;
    logic [15:0] r;
    logic [15:0] po;
    logic c, n, v, z;
    case (op[5:1])
      5'd0:    s = {1'b0, a} + {1'b0, b};
      5'd1:    s = {1'b0, a} + {1'b0, b} + {16'd0, p[0]};
      5'd5:    s = {1'b0, a} - {1'b0, b};
      5'd9:    s = {1'b0, a & b};
      default: s = {1'b0, a ^ b ^ {10'd0, op}};
    endcase
    if (op[0]) begin
      r = {8'h00, s[7:0]};
      c = s[8];
      n = s[7];
      v = (op[5:1] <= 5'd1) && (a[7] == b[7]) && (s[7] != a[7]);
    end else begin
      r = s[15:0];
      c = s[16];
      n = s[15];
      v = (op[5:1] <= 5'd1) && (a[15] == b[15]) && (s[15] != a[15]);
    end
    z  = (r == 16'h0000);
    po = opt ? {p[15:5], v, n ^ v, n, z, c} : p;
    return {po, r};
  endfunction

  // Environment: register file with a poke port, and a strobed ALU.
  logic [15:0] rf [8];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_a = '0;
  logic [15:0] poke_d = '0;
  logic [15:0] alu_res_r = '0;
  logic [15:0] alu_psw_r = '0;

  always @(posedge clk) begin
    if (poke_en)        rf[poke_a] <= poke_d;
    else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  end
  always @(posedge clk)
    if (bus.alu_e)
      {alu_psw_r, alu_res_r} <= alu_fn(bus.alu_instr, bus.alu_op1, bus.alu_op2,
                                       bus.alu_psw, bus.alu_opt);

  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];
  assign bus.alu_result = alu_res_r;
  assign bus.alu_psw_o  = alu_psw_r;

  typedef struct {
    logic        err;
    logic        we;
    logic [2:0]  dst;
    logic [15:0] wdata;
    logic [15:0] psw_new;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] psw_in;
    logic [5:0]  instr;
    logic        opt;
    int          done_at;
    int          alue_at;
  } exp_t;

  exp_t        sbq [$];
  logic [15:0] ref_rf [8];
  logic [15:0] ref_psw = PRST;
  int          free_at = 0;
  int          edges = 0;
  int          alu_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got an event at edge %0d, required none", nm, edges);
  endtask

  // Monitor: pops the scoreboard on done, checks the ALU strobe against the head entry.
  initial begin
    exp_t        e;
    logic        psw_pending;
    logic [15:0] psw_exp;
    psw_pending = 1'b0;
    psw_exp     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        psw_pending = 1'b0;
      end else begin
        if (psw_pending) begin
          chk("psw_after_done", 32'(psw), 32'(psw_exp));
          psw_pending = 1'b0;
        end
        if (bus.alu_e) begin
          if (sbq.size() == 0) unexpected("alu_e_without_instr");
          else begin
            chk("alu_e_cycle", 32'(edges), 32'(sbq[0].alue_at));
            chk("alu_op1", 32'(bus.alu_op1), 32'(sbq[0].op1));
            chk("alu_op2", 32'(bus.alu_op2), 32'(sbq[0].op2));
            chk("alu_instr", 32'(bus.alu_instr), 32'(sbq[0].instr));
            chk("alu_opt", 32'(bus.alu_opt), 32'(sbq[0].opt));
            chk("alu_psw", 32'(bus.alu_psw), 32'(sbq[0].psw_in));
            chk("alu_e_exclusive", 32'({done, err, bus.rf_we}), 32'd0);
            alu_cnt++;
          end
        end
        if (done) begin
          if (sbq.size() == 0) unexpected("done_without_instr");
          else begin
            e = sbq.pop_front();
            chk("done_latency", 32'(edges), 32'(e.done_at));
            chk("err_flag", 32'(err), 32'(e.err));
            chk("rf_we", 32'(bus.rf_we), 32'(e.we));
            chk("alu_e_count", 32'(alu_cnt), e.err ? 32'd0 : 32'd1);
            if (e.we) begin
              chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.dst));
              chk("rf_wdata", 32'(bus.rf_wdata), 32'(e.wdata));
              ref_rf[e.dst] = e.wdata;
            end
            ref_psw     = e.psw_new;
            psw_pending = 1'b1;
            psw_exp     = e.psw_new;
            alu_cnt     = 0;
          end
        end else if (bus.rf_we || err) begin
          chk("we_err_without_done", 32'({bus.rf_we, err}), 32'd0);
        end
      end
    end
  end

  // One input cycle; the reference decides acceptance from its own occupancy window.
  task automatic drive_cycle(input logic st, input logic [5:0] ins, input logic [2:0] s,
                             input logic [2:0] d, input logic upd, input logic pw,
                             input logic [15:0] pwd);
    int          t;
    exp_t        e;
    logic [31:0] r;
    start = st; instr_i = ins; src_i = s; dst_i = d;
    psw_upd_i = upd; psw_wr = pw; psw_wdata = pwd;
    t = edges + 1;
    if (t >= free_at) begin
      if (pw) ref_psw = pwd;
      if (st) begin
        e.err = (ins > 6'h1B); e.dst = d; e.instr = ins; e.opt = upd;
        e.op1 = ref_rf[d]; e.op2 = ref_rf[s]; e.psw_in = ref_psw;
        if (e.err) begin
          e.we = 1'b0; e.wdata = '0; e.psw_new = ref_psw;
          e.done_at = t; e.alue_at = -1; free_at = t + 2;
        end else begin
          r = alu_fn(ins, ref_rf[d], ref_rf[s], ref_psw, upd);
          e.we = !(ins inside {6'h0A, 6'h0B, 6'h12, 6'h13});
          e.wdata = r[15:0]; e.psw_new = r[31:16];
          e.done_at = t + 3; e.alue_at = t + 1; free_at = t + 5;
        end
        sbq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 6'h00, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    ref_rf[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    for (int i = 0; i < 8; i++) poke(3'(i), 16'($urandom));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_alu_e", 32'(bus.alu_e), 32'd0);
    chk("rst_psw", 32'(psw), 32'(PRST));
    chk("rst_alu_op1", 32'(bus.alu_op1), 32'd0);
    chk("rst_alu_instr", 32'(bus.alu_instr), 32'd0);
    chk("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
    #2 rst = 1'b0;
    ref_psw = PRST;
    @(negedge clk);

    poke(3'd1, 16'h0005); poke(3'd2, 16'h0003);
    drive_cycle(1'b1, 6'h00, 3'd2, 3'd1, 1'b1, 1'b0, 16'h0000);
    idle(6);
    chk("add_r1", 32'(rf[1]), 32'h0008);
    chk("add_psw", 32'(psw), 32'h0000);

    poke(3'd1, 16'h0003);
    drive_cycle(1'b1, 6'h0A, 3'd2, 3'd1, 1'b1, 1'b0, 16'h0000);
    idle(6);
    chk("cmp_psw", 32'(psw), 32'h0002);
    chk("cmp_r1_kept", 32'(rf[1]), 32'h0003);

    drive_cycle(1'b1, 6'h1F, 3'd0, 3'd0, 1'b1, 1'b0, 16'h0000);
    idle(3);
    chk("illegal_psw_kept", 32'(psw), 32'h0002);

    poke(3'd1, 16'h0001); poke(3'd2, 16'h0001);
    drive_cycle(1'b1, 6'h02, 3'd2, 3'd1, 1'b1, 1'b1, 16'h0001);
    idle(6);
    chk("addc_r1", 32'(rf[1]), 32'h0003);

    drive_cycle(1'b1, 6'h00, 3'd2, 3'd1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 6'h04, 3'd3, 3'd4, 1'b1, 1'b1, 16'hFFFF);
    idle(4);
    chk("busy_start_ignored_r1", 32'(rf[1]), 32'h0004);

    drive_cycle(1'b1, 6'h00, 3'd2, 3'd1, 1'b1, 1'b0, 16'h0000);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_alu_e", 32'(bus.alu_e), 32'd0);
    chk("abort_rf_we", 32'(bus.rf_we), 32'd0);
    chk("abort_psw", 32'(psw), 32'(PRST));
    sbq.delete();
    alu_cnt = 0;
    ref_psw = PRST;
    free_at = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idle(2);
    chk("abort_r1_kept", 32'(rf[1]), 32'h0004);
    drive_cycle(1'b1, 6'h00, 3'd2, 3'd1, 1'b1, 1'b0, 16'h0000);
    idle(6);
    chk("post_abort_add_r1", 32'(rf[1]), 32'h0005);

    for (int i = 0; i < 700; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(28, 63)) : 6'($urandom_range(0, 27));
      drive_cycle(1'($urandom_range(0, 2) == 0), op, 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom_range(0, 5) == 0), 16'($urandom));
    end

    for (int i = 0; i < 20 && (sbq.size() != 0 || busy); i++) idle(1);
    idle(2);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), 32'(rf[i]), 32'(ref_rf[i]));
    chk("final_psw", 32'(psw), 32'(ref_psw));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
